// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) responder for a single 7-bit address.
// Oversamples SCL/SDA on clk, detects START/STOP/repeated START, matches TARGET_ADDR,
// accepts write bytes or serves read bytes, and returns ACK/NACK. SDA is driven
// open-drain through sda_oe only. SCL is never driven, so there is no clock stretching.
// Ports:
//   clk, rst_n          system clock (>= 10x SCL) and async active-low reset
//   scl_i, sda_i        asynchronous pad inputs
//   sda_oe              1 = pull SDA low
//   rx_data, rx_valid   last written byte and its 1-clk update strobe
//   rx_ready            0 at the 8th write bit -> that byte is NACKed
//   tx_data, tx_req     read byte source; tx_req marks the cycle tx_data is captured
//   rw, addressed, busy transaction direction, address-ACKed flag, START..STOP flag
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       rw,
   output logic       addressed,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_ACK_A  = 3'd2,
      ST_WRITE  = 3'd3,
      ST_ACK_W  = 3'd4,
      ST_READ   = 3'd5,
      ST_ACK_R  = 3'd6,
      ST_IGNORE = 3'd7
   } state_t;

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;

   state_t     r_state,     w_state_nxt;
   logic [3:0] r_bit_cnt,   w_bit_cnt_nxt;
   logic [7:0] r_shift,     w_shift_nxt;
   logic       r_sda_oe,    w_sda_oe_nxt;
   logic [7:0] r_rx_data,   w_rx_data_nxt;
   logic       r_rx_valid,  w_rx_valid_nxt;
   logic       r_tx_req,    w_tx_req_nxt;
   logic       r_rw,        w_rw_nxt;
   logic       r_addressed, w_addressed_nxt;
   logic       r_busy,      w_busy_nxt;
   logic       r_ack,       w_ack_nxt;

   logic       w_scl;
   logic       w_sda;
   logic       w_scl_rise;
   logic       w_scl_fall;
   logic       w_start;
   logic       w_stop;
   logic [7:0] w_byte;

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   // SCL must be high on both sides of the SDA edge for a bus condition.
   assign w_start    = ~w_sda & r_sda_d & w_scl & r_scl_d;
   assign w_stop     = w_sda & ~r_sda_d & w_scl & r_scl_d;
   assign w_byte     = {r_shift[6:0], w_sda};

   assign sda_oe    = r_sda_oe;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign tx_req    = r_tx_req;
   assign rw        = r_rw;
   assign addressed = r_addressed;
   assign busy      = r_busy;

   // Pad synchronisers plus one history flop for edge detection; idle bus reads high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync <= {SYNC_STAGES{1'b1}};
         r_sda_sync <= {SYNC_STAGES{1'b1}};
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
      end
   end

   // Protocol state and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= 4'd0;
         r_shift     <= 8'd0;
         r_sda_oe    <= 1'b0;
         r_rx_data   <= 8'd0;
         r_rx_valid  <= 1'b0;
         r_tx_req    <= 1'b0;
         r_rw        <= 1'b0;
         r_addressed <= 1'b0;
         r_busy      <= 1'b0;
         r_ack       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_sda_oe    <= w_sda_oe_nxt;
         r_rx_data   <= w_rx_data_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_tx_req    <= w_tx_req_nxt;
         r_rw        <= w_rw_nxt;
         r_addressed <= w_addressed_nxt;
         r_busy      <= w_busy_nxt;
         r_ack       <= w_ack_nxt;
      end
   end

   // Next-state logic: bus conditions first, then per-state bit handling.
   always_comb begin
      w_state_nxt     = r_state;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_sda_oe_nxt    = r_sda_oe;
      w_rx_data_nxt   = r_rx_data;
      w_rx_valid_nxt  = 1'b0;
      w_tx_req_nxt    = 1'b0;
      w_rw_nxt        = r_rw;
      w_addressed_nxt = r_addressed;
      w_busy_nxt      = r_busy;
      w_ack_nxt       = r_ack;

      if (w_start) begin
         w_state_nxt     = ST_ADDR;
         w_bit_cnt_nxt   = 4'd0;
         w_busy_nxt      = 1'b1;
         w_addressed_nxt = 1'b0;
         w_sda_oe_nxt    = 1'b0;
      end else if (w_stop) begin
         w_state_nxt     = ST_IDLE;
         w_bit_cnt_nxt   = 4'd0;
         w_busy_nxt      = 1'b0;
         w_addressed_nxt = 1'b0;
         w_sda_oe_nxt    = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_sda_oe_nxt = 1'b0;
            end
            // bit_cnt == 8 means the byte is complete and the ACK slot starts at the next fall.
            ST_ADDR: begin
               if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                  w_shift_nxt   = w_byte;
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd7) begin
                     if ((w_byte[7:1] == TARGET_ADDR) && (w_byte[7:1] != 7'd0)) begin
                        w_rw_nxt = w_byte[0];
                     end else begin
                        w_state_nxt = ST_IGNORE;
                     end
                  end else begin
                  end
               end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                  w_sda_oe_nxt    = 1'b1;
                  w_addressed_nxt = 1'b1;
                  w_state_nxt     = ST_ACK_A;
               end else begin
               end
            end
            ST_ACK_A: begin
               if (w_scl_fall) begin
                  w_bit_cnt_nxt = 4'd0;
                  if (r_rw) begin
                     w_tx_req_nxt = 1'b1;
                     w_state_nxt  = ST_READ;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     w_state_nxt  = ST_WRITE;
                  end
               end else begin
               end
            end
            ST_WRITE: begin
               if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                  w_shift_nxt   = w_byte;
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd7) begin
                     w_rx_data_nxt  = w_byte;
                     w_rx_valid_nxt = 1'b1;
                     w_ack_nxt      = rx_ready;
                  end else begin
                  end
               end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                  w_sda_oe_nxt = r_ack;
                  w_state_nxt  = ST_ACK_W;
               end else begin
               end
            end
            ST_ACK_W: begin
               if (w_scl_fall) begin
                  w_sda_oe_nxt  = 1'b0;
                  w_bit_cnt_nxt = 4'd0;
                  w_state_nxt   = r_ack ? ST_WRITE : ST_IGNORE;
               end else begin
               end
            end
            // tx_data is captured in the cycle tx_req is high; bit 7 goes out right after.
            ST_READ: begin
               if (r_tx_req) begin
                  w_shift_nxt  = tx_data;
                  w_sda_oe_nxt = ~tx_data[7];
               end else if (w_scl_fall) begin
                  if (r_bit_cnt == 4'd7) begin
                     w_sda_oe_nxt = 1'b0;
                     w_ack_nxt    = 1'b0;
                     w_state_nxt  = ST_ACK_R;
                  end else begin
                     w_shift_nxt   = {r_shift[6:0], r_shift[7]};
                     w_sda_oe_nxt  = ~r_shift[6];
                     w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  end
               end else begin
               end
            end
            ST_ACK_R: begin
               if (w_scl_rise) begin
                  if (!w_sda) begin
                     w_ack_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_IGNORE;
                  end
               end else if (w_scl_fall && r_ack) begin
                  w_tx_req_nxt  = 1'b1;
                  w_bit_cnt_nxt = 4'd0;
                  w_state_nxt   = ST_READ;
               end else begin
               end
            end
            ST_IGNORE: begin
               w_sda_oe_nxt = 1'b0;
            end
            default: begin
               w_state_nxt  = ST_IDLE;
               w_sda_oe_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule
